// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial arithmetic blocks.
package serial_arith_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } serial_state_t;

endpackage

// File: rtl/full_subtractor.sv
// Combinational 1-bit full subtractor: d = a - b - bin, with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock, with a
// start/busy/done handshake. A single full-subtractor cell is reused.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] d,
  output logic             borrow,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  serial_state_t state_reg, state_next;

  logic [WIDTH-1:0] sa_reg, sb_reg, res_reg, d_reg;
  logic [WIDTH-1:0] res_shifted;
  logic [CW-1:0]    count_reg;
  logic             bin_reg, borrow_reg, busy_reg, done_reg;
  logic             d_bit, bout;
  logic             load, last_bit;

  full_subtractor u_cell (
    .a    (sa_reg[0]),
    .b    (sb_reg[0]),
    .bin  (bin_reg),
    .d    (d_bit),
    .bout (bout)
  );

  // New difference bits enter at the MSB so the LSB lands in bit 0 after WIDTH shifts.
  assign res_shifted = {d_bit, res_reg[WIDTH-1:1]};
  assign last_bit    = (count_reg == CNT_LAST);

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      sa_reg     <= '0;
      sb_reg     <= '0;
      res_reg    <= '0;
      bin_reg    <= 1'b0;
      count_reg  <= '0;
      d_reg      <= '0;
      borrow_reg <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= (state_next == SHIFT);
      done_reg  <= (state_next == DONE);
      if (load) begin
        sa_reg    <= a;
        sb_reg    <= b;
        res_reg   <= '0;
        bin_reg   <= 1'b0;
        count_reg <= '0;
      end else if (state_reg == SHIFT) begin
        sa_reg  <= sa_reg >> 1;
        sb_reg  <= sb_reg >> 1;
        res_reg <= res_shifted;
        bin_reg <= bout;
        if (last_bit) begin
          d_reg      <= res_shifted;
          borrow_reg <= bout;
        end else begin
          count_reg <= count_reg + 1'b1;
        end
      end
    end
  end

  assign d      = d_reg;
  assign borrow = borrow_reg;
  assign busy   = busy_reg;
  assign done   = done_reg;

endmodule
